// File: rtl/mpeg_sys_pkg.sv
// MPEG-1 system stream demux: shared constants,
// parser state encoding and PES flag-byte patterns.
package mpeg_sys_pkg;

  localparam logic [7:0] SC_PACK    = 8'hBA;
  localparam logic [7:0] SC_SYSHDR  = 8'hBB;
  localparam logic [7:0] SC_END     = 8'hB9;
  localparam logic [7:0] SC_PAD     = 8'hBE;
  localparam logic [7:0] SC_PRIV2   = 8'hBF;
  localparam logic [7:0] SC_PES_MIN = 8'hBC;

  localparam int MAX_STUFF_DEF    = 16;
  localparam int PACK_HDR_LEN_DEF = 8;

  localparam logic [7:0] PES_STUFF = 8'hFF;
  localparam logic [7:0] PES_NO_TS = 8'h0F;
  localparam logic [1:0] PES_STD   = 2'b01;
  localparam logic [2:0] PES_TS    = 3'b001;

  typedef enum logic [3:0] {
    S_SYNC0,
    S_SYNC1,
    S_SYNC2,
    S_STREAM_ID,
    S_PACK,
    S_LEN_HI,
    S_LEN_LO,
    S_SKIP,
    S_HDR,
    S_STD1,
    S_PTS,
    S_DTS,
    S_PAYLOAD
  } state_t;

  function automatic logic is_skip_id(
    input logic [7:0] id
  );
    return (id == SC_SYSHDR) ||
           (id == SC_PAD) ||
           (id == SC_PRIV2);
  endfunction

endpackage

// File: rtl/mpeg_pes_timestamp_capture.sv
// Collects the five PTS bytes of a PES header and
// assembles the 33-bit timestamp, dropping marker bits.
module mpeg_pes_timestamp_capture (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        first,
  input  logic [7:0]  data,
  output logic [32:0] pts,
  output logic        pts_valid
);

  logic [25:0] acc;
  logic [2:0]  idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      idx       <= '0;
      pts       <= '0;
      pts_valid <= 1'b0;
    end else begin
      pts_valid <= 1'b0;
      if (load) begin
        if (first) begin
          acc <= {23'd0, data[3:1]};
          idx <= 3'd1;
        end else begin
          unique case (idx)
            3'd1, 3'd3: begin
              acc <= {acc[17:0], data};
              idx <= idx + 3'd1;
            end
            3'd2: begin
              acc <= {acc[18:0], data[7:1]};
              idx <= idx + 3'd1;
            end
            3'd4: begin
              pts       <= {acc, data[7:1]};
              pts_valid <= 1'b1;
              idx       <= 3'd0;
            end
            default: idx <= 3'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/mpeg_system_video_demux.sv
// Byte-serial MPEG-1 system demux: forwards payload of
// the selected video PES stream and extracts its PTS.
module mpeg_system_video_demux
  import mpeg_sys_pkg::*;
#(
  parameter int MAX_STUFF    = MAX_STUFF_DEF,
  parameter int PACK_HDR_LEN = PACK_HDR_LEN_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  sys_data,
  input  logic        sys_valid,
  input  logic [3:0]  video_sel,
  output logic [7:0]  mpeg_data,
  output logic        data_valid,
  output logic [32:0] pts,
  output logic        pts_valid,
  output logic        event_pack,
  output logic        event_end,
  output logic        sync_error
);

  state_t      state;
  logic [15:0] len;
  logic [7:0]  len_hi;
  logic [7:0]  sid;
  logic [7:0]  cnt;
  logic [7:0]  stuff;
  logic        keep;
  logic        no_stuff;
  logic        with_dts;

  logic [15:0] rem;
  logic        rem_zero;
  logic        ts_first;
  logic        ts_load;

  // len is never 0 inside counted states; guard keeps it non-wrapping
  assign rem      = (len == 16'd0) ? 16'd0 : len - 16'd1;
  assign rem_zero = (rem == 16'd0);

  assign ts_first = sys_valid && (state == S_HDR) &&
                    (sys_data[7:5] == PES_TS);
  assign ts_load  = ts_first ||
                    (sys_valid && (state == S_PTS));

  mpeg_pes_timestamp_capture u_ts (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ts_load),
    .first     (ts_first),
    .data      (sys_data),
    .pts       (pts),
    .pts_valid (pts_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_SYNC0;
      len        <= '0;
      len_hi     <= '0;
      sid        <= '0;
      cnt        <= '0;
      stuff      <= '0;
      keep       <= 1'b0;
      no_stuff   <= 1'b0;
      with_dts   <= 1'b0;
      mpeg_data  <= '0;
      data_valid <= 1'b0;
      event_pack <= 1'b0;
      event_end  <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      event_pack <= 1'b0;
      event_end  <= 1'b0;
      sync_error <= 1'b0;
      if (sys_valid) begin
        unique case (state)
          S_SYNC0:
            if (sys_data == 8'h00) state <= S_SYNC1;
          S_SYNC1:
            state <= (sys_data == 8'h00) ? S_SYNC2 : S_SYNC0;
          S_SYNC2:
            if (sys_data == 8'h01) state <= S_STREAM_ID;
            else if (sys_data != 8'h00) state <= S_SYNC0;
          S_STREAM_ID: begin
            sid <= sys_data;
            if (sys_data == SC_PACK) begin
              state      <= S_PACK;
              cnt        <= 8'(PACK_HDR_LEN - 1);
              event_pack <= 1'b1;
            end else if (sys_data == SC_END) begin
              state     <= S_SYNC0;
              event_end <= 1'b1;
            end else if (sys_data == {4'hE, video_sel}) begin
              state <= S_LEN_HI;
              keep  <= 1'b1;
            end else if (sys_data >= SC_PES_MIN ||
                         sys_data == SC_SYSHDR) begin
              state <= S_LEN_HI;
              keep  <= 1'b0;
            end else begin
              state      <= S_SYNC0;
              sync_error <= 1'b1;
            end
          end
          S_PACK:
            if (cnt == 8'd0) state <= S_SYNC0;
            else cnt <= cnt - 8'd1;
          S_LEN_HI: begin
            len_hi <= sys_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len      <= {len_hi, sys_data};
            stuff    <= '0;
            no_stuff <= 1'b0;
            with_dts <= 1'b0;
            if ({len_hi, sys_data} == 16'd0)
              state <= S_SYNC0;
            else if (!keep || is_skip_id(sid))
              state <= S_SKIP;
            else
              state <= S_HDR;
          end
          S_SKIP: begin
            len <= rem;
            if (rem_zero) state <= S_SYNC0;
          end
          S_HDR: begin
            len <= rem;
            // any header byte that exhausts len leaves no payload
            if (rem_zero) begin
              sync_error <= 1'b1;
              state      <= S_SYNC0;
            end else begin
              unique case (1'b1)
                sys_data == PES_STUFF:
                  if (no_stuff ||
                      stuff >= 8'(MAX_STUFF)) begin
                    sync_error <= 1'b1;
                    state      <= S_SKIP;
                  end else begin
                    stuff <= stuff + 8'd1;
                  end
                sys_data[7:6] == PES_STD:
                  state <= S_STD1;
                sys_data[7:5] == PES_TS: begin
                  cnt      <= 8'd3;
                  with_dts <= sys_data[4];
                  state    <= S_PTS;
                end
                sys_data == PES_NO_TS:
                  state <= S_PAYLOAD;
                default: begin
                  sync_error <= 1'b1;
                  state      <= S_SKIP;
                end
              endcase
            end
          end
          S_STD1: begin
            len      <= rem;
            no_stuff <= 1'b1;
            if (rem_zero) begin
              sync_error <= 1'b1;
              state      <= S_SYNC0;
            end else begin
              state <= S_HDR;
            end
          end
          S_PTS: begin
            len <= rem;
            if (rem_zero) begin
              sync_error <= 1'b1;
              state      <= S_SYNC0;
            end else if (cnt == 8'd0) begin
              if (with_dts) begin
                state <= S_DTS;
                cnt   <= 8'd4;
              end else begin
                state <= S_PAYLOAD;
              end
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          S_DTS: begin
            len <= rem;
            if (rem_zero) begin
              sync_error <= 1'b1;
              state      <= S_SYNC0;
            end else if (cnt == 8'd0) begin
              state <= S_PAYLOAD;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          S_PAYLOAD: begin
            len        <= rem;
            mpeg_data  <= sys_data;
            data_valid <= 1'b1;
            if (rem_zero) state <= S_SYNC0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpeg_system_video_demux.sv
// Bench for mpeg_system_video_demux: stream-level model
// predicts the ordered output events of each segment.
module tb_mpeg_system_video_demux;

  typedef logic [7:0] bq_t[$];

  localparam int K_DATA = 0;
  localparam int K_PTS  = 1;
  localparam int K_PACK = 2;
  localparam int K_END  = 3;
  localparam int K_ERR  = 4;

  typedef struct {
    int          kind;
    logic [32:0] val;
  } item_t;

  logic        clk;
  logic        reset_n;
  logic [7:0]  sys_data;
  logic        sys_valid;
  logic [3:0]  video_sel;
  logic [7:0]  mpeg_data;
  logic        data_valid;
  logic [32:0] pts;
  logic        pts_valid;
  logic        event_pack;
  logic        event_end;
  logic        sync_error;

  item_t       exp_q[$];
  logic [32:0] exp_pts;
  bq_t         got;
  int          n_cmp;
  int          n_bad;
  int          n_pack;
  int          n_end;
  int          n_err;
  int          n_pts;

  mpeg_system_video_demux dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sys_data   (sys_data),
    .sys_valid  (sys_valid),
    .video_sel  (video_sel),
    .mpeg_data  (mpeg_data),
    .data_valid (data_valid),
    .pts        (pts),
    .pts_valid  (pts_valid),
    .event_pack (event_pack),
    .event_end  (event_end),
    .sync_error (sync_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [32:0] act,
                     input logic [32:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, req);
    end
  endtask

  function automatic void push(input int k,
                               input logic [32:0] v);
    item_t it;
    it.kind = k;
    it.val  = v;
    exp_q.push_back(it);
  endfunction

  // Stream-level model: walks start codes and PES fields
  function automatic void model(input bq_t s,
                                input logic [3:0] vs);
    int n, i, z, len, e, j, stuff;
    bit std, pay, bad;
    logic [7:0] b, id, b0, b2, b4;
    n = s.size();
    i = 0;
    z = 0;
    while (i < n) begin
      b = s[i];
      i++;
      if (b == 8'h00) begin
        z++;
        continue;
      end
      if (b != 8'h01 || z < 2) begin
        z = 0;
        continue;
      end
      z = 0;
      if (i >= n) return;
      id = s[i];
      i++;
      if (id == 8'hBA) begin
        push(K_PACK, 0);
        i += 8;
        continue;
      end
      if (id == 8'hB9) begin
        push(K_END, 0);
        continue;
      end
      if (id != {4'hE, vs} && id < 8'hBB) begin
        push(K_ERR, 0);
        continue;
      end
      if (i + 2 > n) return;
      len = {16'd0, s[i], s[i+1]};
      i += 2;
      e = i + len;
      if (len == 0) continue;
      if (id != {4'hE, vs}) begin
        i = e;
        continue;
      end
      j = i;
      stuff = 0;
      std = 0;
      pay = 0;
      bad = 0;
      while (!pay && !bad) begin
        if (j >= e) begin
          bad = 1;
          break;
        end
        if (j >= n) return;
        b = s[j];
        if (b == 8'hFF) begin
          stuff++;
          j++;
          if (std || stuff > 16) bad = 1;
        end else if (b[7:6] == 2'b01) begin
          std = 1;
          j += 2;
        end else if (b[7:5] == 3'b001) begin
          if (j + 5 <= e && j + 5 <= n) begin
            b0 = s[j];
            b2 = s[j+2];
            b4 = s[j+4];
            push(K_PTS, {b0[3:1], s[j+1], b2[7:1],
                         s[j+3], b4[7:1]});
          end
          j += b[4] ? 10 : 5;
          if (j >= e) bad = 1;
          else pay = 1;
        end else if (b == 8'h0F) begin
          j++;
          if (j >= e) bad = 1;
          else pay = 1;
        end else begin
          bad = 1;
        end
      end
      if (bad) begin
        push(K_ERR, 0);
      end else begin
        for (int k = j; k < e; k++) begin
          if (k >= n) return;
          push(K_DATA, {25'd0, s[k]});
        end
      end
      i = e;
    end
  endfunction

  task automatic take(input int k,
                      input logic [32:0] v);
    item_t it;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected output: kind %0d val %0h",
               k, v);
    end else begin
      it = exp_q.pop_front();
      chk("output kind", 33'(k), 33'(it.kind));
      chk("output value", v, it.val);
      if (k == K_PTS && it.kind == K_PTS)
        exp_pts = it.val;
    end
  endtask

  always @(negedge clk) begin
    if (pts_valid) begin
      n_pts++;
      take(K_PTS, pts);
    end
    if (data_valid) begin
      got.push_back(mpeg_data);
      take(K_DATA, {25'd0, mpeg_data});
    end
    if (event_pack) begin
      n_pack++;
      take(K_PACK, 0);
    end
    if (event_end) begin
      n_end++;
      take(K_END, 0);
    end
    if (sync_error) begin
      n_err++;
      take(K_ERR, 0);
    end
    chk("pts hold", pts, exp_pts);
  end

  task automatic send(input logic [7:0] b);
    sys_data  = b;
    sys_valid = 1'b1;
    @(posedge clk);
    #1;
    sys_valid = 1'b0;
  endtask

  task automatic idle(input int c);
    sys_valid = 1'b0;
    sys_data  = 8'h01;
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got.delete();
    n_pack = 0;
    n_end  = 0;
    n_err  = 0;
    n_pts  = 0;
  endtask

  task automatic run(input bq_t q,
                     input logic [3:0] vs,
                     input int stall_at);
    video_sel = vs;
    model(q, vs);
    foreach (q[k]) begin
      if (k == stall_at) idle(3);
      send(q[k]);
    end
    idle(3);
    chk("queue drained", 33'(exp_q.size()), 33'd0);
  endtask

  task automatic expect_got(input string name,
                            input bq_t w);
    chk(name, 33'(got.size()), 33'(w.size()));
    foreach (w[k])
      if (k < got.size())
        chk(name, {25'd0, got[k]}, {25'd0, w[k]});
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    sys_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_pts = 33'd0;
    reset_n = 1'b1;
  endtask

  initial begin
    bq_t q;
    bq_t w;
    n_cmp     = 0;
    n_bad     = 0;
    exp_pts   = 33'd0;
    reset_n   = 1'b0;
    sys_valid = 1'b0;
    sys_data  = 8'h00;
    video_sel = 4'h0;
    clr();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset data_valid", 33'(data_valid), 33'd0);
    chk("reset mpeg_data", 33'(mpeg_data), 33'd0);
    chk("reset pts", pts, 33'd0);
    chk("reset event_pack", 33'(event_pack), 33'd0);
    chk("reset sync_error", 33'(sync_error), 33'd0);
    @(posedge clk);
    #1;

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h08,
          8'h0F, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
          8'hFF, 8'h11};
    run(q, 4'h0, -1);
    w = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
          8'hFF, 8'h11};
    expect_got("t1 payload", w);

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h0A,
          8'h21, 8'h00, 8'h01, 8'h00, 8'h03,
          8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    run(q, 4'h0, -1);
    chk("t2 pts", pts, 33'h000000001);
    chk("t2 pts pulses", 33'(n_pts), 33'd1);
    chk("t2 bytes", 33'(got.size()), 33'd5);

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hE1, 8'h00, 8'h04,
          8'h0F, 8'h01, 8'h02, 8'h03,
          8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h03,
          8'h0F, 8'h55, 8'h66};
    run(q, 4'h0, -1);
    w = '{8'h55, 8'h66};
    expect_got("t3 payload", w);

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h11};
    repeat (17) q.push_back(8'hFF);
    w = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h44, 8'h00,
          8'h04, 8'h00, 8'h04, 8'h01, 8'h01, 8'h89};
    foreach (w[k]) q.push_back(w[k]);
    run(q, 4'h0, -1);
    chk("t4 sync_error", 33'(n_err), 33'd1);
    chk("t4 event_pack", 33'(n_pack), 33'd1);
    chk("t4 no data", 33'(got.size()), 33'd0);

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h09,
          8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
          8'h15, 8'h16, 8'h17};
    run(q, 4'h0, 10);
    w = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
          8'h15, 8'h16, 8'h17};
    expect_got("t5 stall payload", w);

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h09,
          8'h0F, 8'h20, 8'h21, 8'h22};
    run(q, 4'h0, -1);
    do_reset();
    @(negedge clk);
    chk("t5 reset data_valid", 33'(data_valid), 33'd0);
    chk("t5 reset pts", pts, 33'd0);
    q = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    run(q, 4'h0, -1);
    w = '{8'h20, 8'h21, 8'h22};
    expect_got("t5 no partial", w);
    chk("t5 pts after tail", pts, 33'd0);

    clr();
    q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hB9,
          8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h06,
          8'h0F, 8'h00, 8'h00, 8'h01, 8'hB3, 8'h42};
    run(q, 4'h0, -1);
    chk("t6 event_end", 33'(n_end), 33'd1);
    chk("t6 no pack", 33'(n_pack), 33'd0);
    chk("t6 no error", 33'(n_err), 33'd0);
    w = '{8'h00, 8'h00, 8'h01, 8'hB3, 8'h42};
    expect_got("t6 verbatim", w);

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hE2, 8'h00, 8'h0C,
          8'h31, 8'h00, 8'h01, 8'h00, 8'h05,
          8'h11, 8'h00, 8'h01, 8'h00, 8'h01,
          8'hC1, 8'hC2};
    run(q, 4'h2, -1);
    chk("t7 pts", pts, 33'h000000002);
    w = '{8'hC1, 8'hC2};
    expect_got("t7 payload", w);

    clr();
    q = '{8'h00, 8'h00, 8'h01, 8'hBB, 8'h00, 8'h03,
          8'h01, 8'h02, 8'h03,
          8'h00, 8'h00, 8'h01, 8'hBE, 8'h00, 8'h02,
          8'hFF, 8'hFF,
          8'h00, 8'h00, 8'h01, 8'hB0,
          8'h00, 8'h00, 8'h01, 8'hE2, 8'h00, 8'h07,
          8'hFF, 8'hFF, 8'h40, 8'h00, 8'h0F,
          8'h99, 8'h88,
          8'h00, 8'h00, 8'h01, 8'hE2, 8'h00, 8'h02,
          8'hFF, 8'hFF};
    run(q, 4'h2, -1);
    chk("t8 errors", 33'(n_err), 33'd2);
    w = '{8'h99, 8'h88};
    expect_got("t8 payload", w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
